// File: rtl/tick_sequencer_pkg.sv
// Shared widths and state encoding for the tick sequencer and the counter/adder top level.
package tick_sequencer_pkg;

  localparam int unsigned DIV_W = 27;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    HOLD = ST_HOLD,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/tick_sequencer_if.sv
// Control/status bundle between the run controller and the tick sequencer.
interface tick_sequencer_if;
  import tick_sequencer_pkg::*;

  logic             start;
  logic             stop;
  logic             pause;
  logic [DIV_W-1:0] div_val;
  logic [CNT_W-1:0] steps;
  logic             tick;
  logic [CNT_W-1:0] step_idx;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, stop, pause, div_val, steps,
    input  tick, step_idx, busy, done, aborted
  );

  modport slave (
    input  start, stop, pause, div_val, steps,
    output tick, step_idx, busy, done, aborted
  );

endinterface

// File: rtl/tick_prescaler.sv
// Synchronous 0..div_q counter; wrap flags the terminal count so the FSM can issue a tick.
module tick_prescaler
  import tick_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_q,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt;

  // Unqualified by en so the FSM can decide whether the wrap is taken this cycle.
  assign wrap = (cnt == div_q);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Single-clock sequencer: releases exactly 'steps' prescaled tick strobes, then reports done/aborted.
module tick_sequencer
  import tick_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  tick_sequencer_if.slave bus
);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] idx_q, idx_n, idx_inc;
  logic             tick_q, tick_n;
  logic             done_q, done_n;
  logic             aborted_q, aborted_n;
  logic             busy_q;
  logic             latch, clr, en, wrap;

  tick_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .div_q (div_q),
    .wrap  (wrap)
  );

  assign idx_inc = idx_q + CNT_W'(1);

  // Next state and strobes; HOLD with pause released counts like RUN so no cycle is lost on resume.
  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    tick_n    = 1'b0;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    latch     = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.steps != '0) begin
            latch   = 1'b1;
            clr     = 1'b1;
            idx_n   = '0;
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN, HOLD: begin
        if (bus.stop) begin
          aborted_n = 1'b1;
          state_n   = IDLE;
        end else if (bus.pause) begin
          state_n = HOLD;
        end else begin
          en      = 1'b1;
          state_n = RUN;
          if (wrap) begin
            tick_n = 1'b1;
            idx_n  = idx_inc;
            if (idx_inc == steps_q) begin
              state_n = DONE;
            end
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_q     <= '0;
      steps_q   <= '0;
      idx_q     <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      tick_q    <= tick_n;
      done_q    <= done_n;
      aborted_q <= aborted_n;
      busy_q    <= (state_n == RUN) || (state_n == HOLD);
      if (latch) begin
        div_q   <= bus.div_val;
        steps_q <= bus.steps;
      end
    end
  end

  assign bus.tick     = tick_q;
  assign bus.step_idx = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: timing, pause deferral, stop abort, zero steps and reset.
module tb_tick_sequencer;
  import tick_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   tcount;

  tick_sequencer_if bus ();

  tick_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_idle(input string tag, input logic [31:0] idx_exp);
    chk({tag, ".tick"},    32'(bus.tick),     32'd0);
    chk({tag, ".busy"},    32'(bus.busy),     32'd0);
    chk({tag, ".done"},    32'(bus.done),     32'd0);
    chk({tag, ".aborted"}, 32'(bus.aborted),  32'd0);
    chk({tag, ".idx"},     32'(bus.step_idx), idx_exp);
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.div_val = '0;
    bus.steps   = '0;
    cyc();
    cyc();
    chk_all_idle("reset", 32'd0);
    rst = 1'b0;
    cyc();

    // 1: div 2, steps 3 -> ticks at E+3, E+6, E+9; done at E+10; mid-run input changes ignored
    bus.div_val = DIV_W'(2);
    bus.steps   = CNT_W'(3);
    bus.start   = 1'b1;
    cyc();
    bus.start   = 1'b0;
    bus.div_val = DIV_W'(9);
    bus.steps   = CNT_W'(1);
    chk("t1.busy_e0", 32'(bus.busy), 32'd1);
    chk("t1.tick_e0", 32'(bus.tick), 32'd0);
    tcount = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (bus.tick) tcount++;
      chk($sformatf("t1.tick_e%0d", k), 32'(bus.tick), 32'((k % 3) == 0));
      chk($sformatf("t1.idx_e%0d", k), 32'(bus.step_idx), 32'(k / 3));
      chk($sformatf("t1.done_e%0d", k), 32'(bus.done), 32'd0);
    end
    chk("t1.busy_e9", 32'(bus.busy), 32'd0);
    cyc();
    chk("t1.done_e10", 32'(bus.done), 32'd1);
    chk("t1.tick_e10", 32'(bus.tick), 32'd0);
    chk("t1.idx_e10", 32'(bus.step_idx), 32'd3);
    cyc();
    chk("t1.done_e11", 32'(bus.done), 32'd0);
    chk("t1.count", 32'(tcount), 32'd3);

    // 2: div 0, steps 4 with start held -> 4 back-to-back ticks, no restart before IDLE
    bus.div_val = DIV_W'(0);
    bus.steps   = CNT_W'(4);
    bus.start   = 1'b1;
    cyc();
    chk("t2.tick_e0", 32'(bus.tick), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("t2.tick_e%0d", k), 32'(bus.tick), 32'd1);
      chk($sformatf("t2.idx_e%0d", k), 32'(bus.step_idx), 32'(k));
    end
    cyc();
    chk("t2.done_e5", 32'(bus.done), 32'd1);
    chk("t2.busy_e5", 32'(bus.busy), 32'd0);
    chk("t2.tick_e5", 32'(bus.tick), 32'd0);
    bus.start = 1'b0;
    cyc();
    chk_all_idle("t2.e6", 32'd4);

    // 3: div 3, steps 2, pause 5 cycles when a tick is due -> tick moves from E+4 to E+9
    bus.div_val = DIV_W'(3);
    bus.steps   = CNT_W'(2);
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
    tcount = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (bus.tick) tcount++;
      chk($sformatf("t3.tick_e%0d", k), 32'(bus.tick), 32'((k == 9) || (k == 13)));
      chk($sformatf("t3.done_e%0d", k), 32'(bus.done), 32'(k == 14));
      if (k >= 4 && k <= 8) begin
        chk($sformatf("t3.busy_e%0d", k), 32'(bus.busy), 32'd1);
        chk($sformatf("t3.idx_e%0d", k), 32'(bus.step_idx), 32'd0);
      end
      if (k == 3) bus.pause = 1'b1;
      if (k == 8) bus.pause = 1'b0;
    end
    chk("t3.count", 32'(tcount), 32'd2);
    chk("t3.idx_end", 32'(bus.step_idx), 32'd2);

    // 4: div 1, steps 3, stop on the cycle the second tick is due
    bus.div_val = DIV_W'(1);
    bus.steps   = CNT_W'(3);
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("t4.tick_e%0d", k), 32'(bus.tick), 32'(k == 2));
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t4.tick_e4", 32'(bus.tick), 32'd0);
    chk("t4.aborted_e4", 32'(bus.aborted), 32'd1);
    chk("t4.idx_e4", 32'(bus.step_idx), 32'd1);
    chk("t4.busy_e4", 32'(bus.busy), 32'd0);
    chk("t4.done_e4", 32'(bus.done), 32'd0);
    for (int k = 5; k <= 8; k++) begin
      cyc();
      chk_all_idle($sformatf("t4.e%0d", k), 32'd1);
    end

    // 5a: steps 0 -> no tick, done two edges after start is raised
    bus.steps = CNT_W'(0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("t5.tick_e0", 32'(bus.tick), 32'd0);
    chk("t5.busy_e0", 32'(bus.busy), 32'd0);
    chk("t5.done_e0", 32'(bus.done), 32'd0);
    cyc();
    chk("t5.done_e1", 32'(bus.done), 32'd1);
    chk("t5.tick_e1", 32'(bus.tick), 32'd0);
    cyc();
    chk("t5.done_e2", 32'(bus.done), 32'd0);

    // 5b: reset mid-run -> all outputs at reset value, no done afterwards
    bus.div_val = DIV_W'(2);
    bus.steps   = CNT_W'(5);
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t5.tick_e3", 32'(bus.tick), 32'd1);
    chk("t5.idx_e3", 32'(bus.step_idx), 32'd1);
    rst = 1'b1;
    cyc();
    chk_all_idle("t5.rst", 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk_all_idle($sformatf("t5.post%0d", k), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
